// File: rtl/mux_rr_arbiter_if.sv
// Requester-side bundle of the round-robin mux arbiter: per-requester request/data in,
// one-hot grant, mux key and registered muxed data out.
interface mux_rr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  localparam int SEL_W = $clog2(NREQ);

  // Handshake: a requester raises req[i] and holds it high for its whole transfer;
  // gnt[i] answers one cycle later. Dropping req[i] while granted ends the transfer.
  // out_valid qualifies out_data one cycle behind the grant; there is no backpressure.
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] data;
  logic [NREQ-1:0]    gnt;
  logic [SEL_W-1:0]   sel;
  logic               out_valid;
  logic [DW-1:0]      out_data;

  modport master (output req, data, input gnt, sel, out_valid, out_data);
  modport slave  (input req, data, output gnt, sel, out_valid, out_data);
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one key-selected N:1 data mux among NREQ requesters,
// with a bounded hold time and a registered muxed output.
module mux_rr_arbiter #(
  parameter int NREQ     = 4,
  parameter int DW       = 8,
  parameter int MAX_HOLD = 8,
  localparam int SEL_W   = $clog2(NREQ),
  localparam int CNT_W   = $clog2(MAX_HOLD + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  mux_rr_arbiter_if.slave  bus,
  output logic             state_dbg,
  output logic [CNT_W-1:0] cnt_dbg
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;

  logic [NREQ-1:0]  mask;
  logic [SEL_W-1:0] start;
  logic [SEL_W-1:0] cand;
  logic [SEL_W-1:0] idx;
  logic             found;
  logic             release_g;
  logic             timeout_g;

  // In GRANT the current holder is masked and the search starts just past it,
  // so release and timeout both hand over to the next requester in ring order.
  always_comb begin
    mask  = bus.req;
    start = ptr;
    if (state == GRANT) begin
      mask[bus.sel] = 1'b0;
      start         = bus.sel + SEL_W'(1);
    end
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = start + SEL_W'(k);
      if (!found && mask[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

  assign release_g = !bus.req[bus.sel];
  assign timeout_g = bus.req[bus.sel] && (cnt == CNT_W'(MAX_HOLD)) && found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.gnt       <= '0;
      bus.sel       <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      ptr           <= '0;
      cnt           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            bus.gnt <= NREQ'(1) << idx;
            bus.sel <= idx;
            cnt     <= CNT_W'(1);
            state   <= GRANT;
          end
        end
        GRANT: begin
          if (release_g || timeout_g) begin
            ptr <= bus.sel + SEL_W'(1);
            if (found) begin
              bus.gnt <= NREQ'(1) << idx;
              bus.sel <= idx;
              cnt     <= CNT_W'(1);
            end else begin
              bus.gnt <= '0;
              cnt     <= '0;
              state   <= IDLE;
            end
          end else if (cnt != CNT_W'(MAX_HOLD)) begin
            // Saturating count: a lone holder is never preempted.
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase

      if (state == GRANT && bus.req[bus.sel]) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= bus.data[bus.sel*DW +: DW];
      end else begin
        bus.out_valid <= 1'b0;
      end
    end
  end

  assign state_dbg = (state == GRANT);
  assign cnt_dbg   = cnt;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed and randomised checks of mux_rr_arbiter with NREQ=4, DW=8, MAX_HOLD=4.
module tb_mux_rr_arbiter;
  localparam int NREQ     = 4;
  localparam int DW       = 8;
  localparam int MAX_HOLD = 4;
  localparam int CNT_W    = $clog2(MAX_HOLD + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             state_dbg;
  logic [CNT_W-1:0] cnt_dbg;

  int n_cmp = 0;
  int n_err = 0;

  mux_rr_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

  mux_rr_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg),
    .cnt_dbg   (cnt_dbg)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic apply_reset();
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.data = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (bus.gnt !== 4'b0000) begin n_err++; $display("FAIL rst_gnt: got %b want 0000", bus.gnt); end
    n_cmp++; if (bus.sel !== 2'd0) begin n_err++; $display("FAIL rst_sel: got %0d want 0", bus.sel); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_data !== 8'h00) begin n_err++; $display("FAIL rst_data: got %h want 00", bus.out_data); end
    n_cmp++; if (state_dbg !== 1'b0) begin n_err++; $display("FAIL rst_state: got %b want 0", state_dbg); end
    // Grant 2 then release: ptr moves to 3. Then grant 0 and reset mid-grant.
    bus.data = 32'h00C3_003C;
    bus.req  = 4'b0100;
    @(negedge clk);
    bus.req = 4'b0000;
    @(negedge clk);
    bus.req = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h3C) begin
      n_err++; $display("FAIL pre_rst_data: got %b/%h want 1/3c", bus.out_valid, bus.out_data);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.gnt !== 4'b0000) begin n_err++; $display("FAIL async_gnt: got %b want 0000", bus.gnt); end
    n_cmp++; if (bus.sel !== 2'd0) begin n_err++; $display("FAIL async_sel: got %0d want 0", bus.sel); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL async_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_data !== 8'h00) begin n_err++; $display("FAIL async_data: got %h want 00", bus.out_data); end
    @(negedge clk);
    rst_n   = 1'b1;
    bus.req = 4'b1001;
    @(negedge clk);
    n_cmp++; if (bus.gnt !== 4'b0001) begin n_err++; $display("FAIL restart_ptr0: got %b want 0001", bus.gnt); end
    bus.req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_single();
    apply_reset();
    bus.data = 32'h00A5_0000;
    bus.req  = 4'b0100;
    @(negedge clk);
    n_cmp++; if (bus.gnt !== 4'b0100 || bus.sel !== 2'd2) begin
      n_err++; $display("FAIL single_gnt: got %b/%0d want 0100/2", bus.gnt, bus.sel);
    end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL single_lag: got %b want 0", bus.out_valid); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5 || bus.gnt !== 4'b0100) begin
        n_err++; $display("FAIL single_beat%0d: got %b/%h/%b want 1/a5/0100", k, bus.out_valid, bus.out_data, bus.gnt);
      end
    end
    bus.req = 4'b0000;
    @(negedge clk);
    n_cmp++; if (bus.gnt !== 4'b0000 || bus.out_valid !== 1'b0 || bus.out_data !== 8'hA5) begin
      n_err++; $display("FAIL single_end: got %b/%b/%h want 0000/0/a5", bus.gnt, bus.out_valid, bus.out_data);
    end
    n_cmp++; if (state_dbg !== 1'b0) begin n_err++; $display("FAIL single_idle: got %b want 0", state_dbg); end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_gnt;
    logic [7:0] exp_data;
    int idx;
    int pidx;
    apply_reset();
    bus.data = 32'h4433_2211;
    bus.req  = 4'b1111;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      idx     = (k / MAX_HOLD) % NREQ;
      exp_gnt = 4'b0001 << idx;
      n_cmp++; if (bus.gnt !== exp_gnt) begin
        n_err++; $display("FAIL rot_gnt%0d: got %b want %b", k, bus.gnt, exp_gnt);
      end
      if (k >= 1) begin
        pidx     = ((k - 1) / MAX_HOLD) % NREQ;
        exp_data = 8'h11 * 8'(pidx + 1);
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_data) begin
          n_err++; $display("FAIL rot_data%0d: got %b/%h want 1/%h", k, bus.out_valid, bus.out_data, exp_data);
        end
      end
    end
    bus.req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_release_order();
    apply_reset();
    bus.data = 32'h8000_1001;
    bus.req  = 4'b0010;
    @(negedge clk);
    n_cmp++; if (bus.gnt !== 4'b0010) begin n_err++; $display("FAIL ro_first: got %b want 0010", bus.gnt); end
    bus.req = 4'b1011;
    @(negedge clk);
    n_cmp++; if (bus.gnt !== 4'b0010) begin n_err++; $display("FAIL ro_hold: got %b want 0010", bus.gnt); end
    bus.req = 4'b1001;
    @(negedge clk);
    n_cmp++; if (bus.gnt !== 4'b1000 || bus.sel !== 2'd3) begin
      n_err++; $display("FAIL ro_next3: got %b/%0d want 1000/3", bus.gnt, bus.sel);
    end
    @(negedge clk);
    n_cmp++; if (bus.out_data !== 8'h80) begin n_err++; $display("FAIL ro_data3: got %h want 80", bus.out_data); end
    bus.req = 4'b0001;
    @(negedge clk);
    n_cmp++; if (bus.gnt !== 4'b0001) begin n_err++; $display("FAIL ro_next0: got %b want 0001", bus.gnt); end
    bus.req = 4'b0000;
    @(negedge clk);
    n_cmp++; if (bus.gnt !== 4'b0000) begin n_err++; $display("FAIL ro_idle: got %b want 0000", bus.gnt); end
  endtask

  task automatic test_lone_hold();
    logic [CNT_W-1:0] exp_cnt;
    apply_reset();
    bus.req = 4'b0010;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      exp_cnt = (k < MAX_HOLD) ? CNT_W'(k) : CNT_W'(MAX_HOLD);
      n_cmp++; if (bus.gnt !== 4'b0010 || cnt_dbg !== exp_cnt) begin
        n_err++; $display("FAIL lone%0d: got %b/%0d want 0010/%0d", k, bus.gnt, cnt_dbg, exp_cnt);
      end
    end
    bus.req = 4'b0000;
    @(negedge clk);
  endtask

  // Scoreboard: {out_valid, out_data} predicted one cycle ahead.
  logic [DW:0] exp_q[$];

  task automatic test_random();
    int          wait_cnt [NREQ];
    logic [DW:0] exp;
    logic [DW-1:0] last_data;
    logic        ev;
    apply_reset();
    last_data = '0;
    exp_q.delete();
    for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        n_cmp++; if (bus.out_valid !== exp[DW] || bus.out_data !== exp[DW-1:0]) begin
          n_err++; $display("FAIL rnd_data c%0d: got %b/%h want %b/%h", cyc, bus.out_valid, bus.out_data, exp[DW], exp[DW-1:0]);
        end
      end
      n_cmp++; if ($countones(bus.gnt) > 1 || (bus.gnt != 0 && bus.gnt !== (4'b0001 << bus.sel))) begin
        n_err++; $display("FAIL rnd_onehot c%0d: got gnt %b sel %0d", cyc, bus.gnt, bus.sel);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req[i] && !bus.gnt[i]) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        n_cmp++; if (wait_cnt[i] > (NREQ - 1) * MAX_HOLD + 1) begin
          n_err++; $display("FAIL rnd_starve c%0d req%0d: waited %0d want <= %0d", cyc, i, wait_cnt[i], (NREQ - 1) * MAX_HOLD + 1);
        end
      end
      // Requesters only drop while granted, so every transfer is held to completion.
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req[i]) bus.req[i] = ($urandom_range(0, 2) == 0);
        else if (bus.gnt[i]) bus.req[i] = ($urandom_range(0, 3) != 0);
      end
      bus.data = {$urandom(), $urandom()};
      ev = (bus.gnt != 0) && bus.req[bus.sel];
      if (ev) last_data = bus.data[bus.sel*DW +: DW];
      exp_q.push_back({ev, last_data});
      @(negedge clk);
    end
    bus.req = '0;
    @(negedge clk);
  endtask

  initial begin
    bus.req  = '0;
    bus.data = '0;
    test_reset();
    test_single();
    test_rotation();
    test_release_order();
    test_lone_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
